// File: rtl/mult_seq_ctrl_pkg.sv
// rtl/mult_seq_ctrl_pkg.sv - shared constants and types for the multiply sequencer
// Purpose: ALU control codes, ALUOp encodings and the sequencer state encoding.
// Ports: none (package).
package mult_seq_ctrl_pkg;

  // ALU control codes produced by ALU control decode
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRLV = 4'b1111;

  // ALUOp from main decode into ALU control decode
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - execute-stage handshake bundle for the multiply sequencer
// Purpose: groups launch inputs, flush, stall/status and the product.
// Ports (slave view): valid_i, alu_ctrl_i, src1_i, src2_i, flush_i in;
//                     stall_o, busy_o, done_o, product_o out.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               valid_i;
  logic [3:0]         alu_ctrl_i;
  logic [WIDTH-1:0]   src1_i;
  logic [WIDTH-1:0]   src2_i;
  logic               flush_i;
  logic               stall_o;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] product_o;

  modport master (
    output valid_i, alu_ctrl_i, src1_i, src2_i, flush_i,
    input  stall_o, busy_o, done_o, product_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, src1_i, src2_i, flush_i,
    output stall_o, busy_o, done_o, product_o
  );
endinterface

// File: rtl/mult_seq_ctrl_booth_step.sv
// rtl/mult_seq_ctrl_booth_step.sv - one combinational radix-2 Booth iteration
// Purpose: conditional add/sub of sign-extended M into the accumulator, then
//          arithmetic shift right by one.
// Ports: p (2*WIDTH+2 partial product), m (multiplicand) in; p_next out.
module mult_seq_ctrl_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH+1:0] p_next
);

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] pre_shift;

  always_comb begin
    m_ext = {m[WIDTH-1], m};
    upper = p[2*WIDTH+1:WIDTH+1];
    sum   = upper;
    case (p[1:0])
      2'b01:   sum = upper + m_ext;
      2'b10:   sum = upper - m_ext;
      default: sum = upper;
    endcase
    pre_shift = {sum, p[WIDTH:0]};
    p_next    = {pre_shift[2*WIDTH+1], pre_shift[2*WIDTH+1:1]};
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - multi-cycle signed Booth multiply sequencer
// Purpose: launches on the MUL ALU code, stalls the pipeline for WIDTH Booth
//          steps, then strobes done_o with the registered 2*WIDTH product.
// Ports: clk_i, rst_n (async active-low); bus (slave) carries valid_i,
//        alu_ctrl_i, src1_i, src2_i, flush_i and stall_o, busy_o, done_o, product_o.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input logic             clk_i,
  input logic             rst_n,
  mult_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH + 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      p_q, p_next;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               start;
  logic               last_step;
  logic               stall, busy, done;

  assign start     = bus.valid_i && (bus.alu_ctrl_i == MUL_CODE) &&
                     (state_q == ST_IDLE) && !bus.flush_i;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  mult_seq_ctrl_booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_next)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush_i)    state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // stall is released in DONE so the pipeline moves as writeback takes product_o
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: stall = start;
      ST_CALC: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      p_q    <= '0;
      m_q    <= '0;
      prod_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          m_q   <= bus.src1_i;
          p_q   <= {{(WIDTH+1){1'b0}}, bus.src2_i, 1'b0};
          cnt_q <= '0;
        end
        ST_CALC: begin
          if (bus.flush_i) begin
            cnt_q <= '0;
          end else begin
            p_q   <= p_next;
            cnt_q <= cnt_q + CNT_W'(1);
            // capture only the finished product so partial sums never leak out
            if (last_step) prod_q <= p_next[2*WIDTH:1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o   = stall;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.product_o = prod_q;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the datapath's signed multiply (ALU control code 4'b0011).
- Fires on the mult opcode and runs a radix-2 Booth shift-add iteration over WIDTH cycles.
- Freezes the pipeline with stall_o while the multiply is in progress.
- Presents a full 2*WIDTH-bit product with a one-cycle valid strobe for writeback.
- Sits beside the ALU, between ALU control decode and the register-write mux.

Parameters:
- WIDTH, 32, operand width in bits.
- MUL_CODE, 4'b0011, ALU control value that launches a multiply.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  instruction in the execute stage is valid.
- alu_ctrl_i  input  4  ALU control code from ALU control decode.
- src1_i  input  WIDTH  multiplicand (rs), two's complement.
- src2_i  input  WIDTH  multiplier (rt), two's complement.
- flush_i  input  1  abort any in-flight multiply (branch/jump flush).
- stall_o  output  1  hold PC and pipeline registers.
- busy_o  output  1  sequencer is iterating.
- done_o  output  1  one-cycle pulse: product_o is valid and may be written.
- product_o  output  2*WIDTH  signed product; upper half is HI, lower half is LO.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, accumulator=0.
  - stall_o=0, busy_o=0, done_o=0, product_o=0.
- start = valid_i && alu_ctrl_i==MUL_CODE && state==IDLE && !flush_i. This is combinational.
- States:
  - IDLE:
    - On start, latch M=src1_i. Load P={(WIDTH+1)'b0, src2_i, 1'b0}, width 2*WIDTH+2; the upper WIDTH+1 bits are the accumulator.
    - Set counter=0 and go to CALC.
  - CALC, one Booth step per cycle on P[1:0]:
    - 01: upper += sext(M).
    - 10: upper -= sext(M).
    - 00 or 11: no add.
    - Then arithmetic shift P right by 1 and increment counter.
    - After the step where counter reaches WIDTH-1 (WIDTH steps total), go to DONE.
  - DONE:
    - done_o=1 for exactly this cycle; product_o=P[2*WIDTH:1].
    - Return to IDLE next cycle.
- Accumulator is WIDTH+1 bits so M = -2^(WIDTH-1) cannot overflow.
- Latency: start on cycle T gives done_o on cycle T+WIDTH+1 (cycle T+33 for WIDTH=32).
- stall_o:
  - Equals start in IDLE (combinational, same cycle as the launch).
  - 1 throughout CALC.
  - 0 in DONE, so the pipeline advances exactly as writeback consumes product_o.
- busy_o=1 only in CALC.
- product_o is registered. It updates only on entry to DONE and holds its value until the next DONE; it does not change during CALC.
- MUL_CODE with valid_i while in CALC or DONE: ignored. No second launch occurs, and the pipeline is already stalled.
- In DONE, if the next instruction is also a mult, it launches only after the return to IDLE, one bubble later.
- flush_i:
  - In CALC: go to IDLE next cycle, clear counter; no done_o; product_o keeps its previous value.
  - In DONE: done_o still pulses (the result belongs to an older instruction).
  - In IDLE: suppresses start.
- Reset mid-CALC: immediate return to reset values. No partial product is ever visible.
- Operand inputs are sampled only at start; changes during CALC have no effect.

Decomposition:
- Shared package holds:
  - ALU control code constants: AND=0000, OR=0001, ADD=0010, MUL=0011, LUI=0100, SLL=0101, SUB=0110, SLT=0111, SRLV=1111.
  - ALUOp encodings.
  - The state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
- One natural sub-module: booth_step, purely combinational. It takes P and M, produces next P (add/sub plus arithmetic shift), and is parameterised by WIDTH.
- The FSM, counter and registers stay in mult_seq_ctrl.

Test Plan:
- 3 x 5, start at T: stall_o=1 from T through T+32, done_o=1 only at T+33, product_o=64'h0000_0000_0000_000F.
- -7 x 6 -> product_o=64'hFFFF_FFFF_FFFF_FFD6. Then -1 x -1 -> 64'h0000_0000_0000_0001.
- 32'h8000_0000 x 32'h8000_0000 -> 64'h4000_0000_0000_0000. Also 32'h8000_0000 x 32'h7FFF_FFFF -> 64'hC000_0000_8000_0000.
- MUL_CODE held with valid_i=1 and changing operands during CALC -> exactly one done_o, and the product matches the operands captured at start.
- flush_i at cycle T+10 -> IDLE at T+11, no done_o, product_o unchanged; a new start at T+12 completes normally at T+45.
- rst_n low at T+20 of an active multiply -> all outputs 0 asynchronously; after release, 2 x 3 completes with 64'h6 after 33 cycles.
